// File: rtl/ds_requantizer.sv
// Requantizer + error extraction for the delta-sigma error-feedback loop.
// Latency: one CLK; y/err/sat update on the accepting edge, valid pulses the following cycle.
// Backpressure: none; en is a strobe and full-rate back-to-back samples are accepted.
module ds_requantizer #(
    parameter int QBITS  = 4,
    parameter int WARMUP = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic [15:0]      in,
    input  logic [15:0]      fb,
    input  logic             dither_on,
    input  logic             clr,
    output logic [QBITS-1:0] y,
    output logic [15:0]      err,
    output logic             valid,
    output logic             sat,
    output logic [7:0]       sat_count
);

    localparam int          EBITS  = 16 - QBITS;
    localparam logic [7:0]  WARM_N = 8'(WARMUP);
    localparam logic [15:0] SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         warm_cnt_q, warm_cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [QBITS-1:0]   y_q, y_d;
    logic [15:0]        err_q, err_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;
    logic [7:0]         sat_count_q, sat_count_d;

    logic [16:0]        sum_v;
    logic [15:0]        vs;
    logic               sat_now;
    logic               lfsr_fb;
    logic [7:0]         warm_next;

    // 17-bit sum of two sign-extended samples plus dither never wraps.
    always_comb begin
        sum_v   = {in[15], in} + {fb[15], fb} + {16'b0, dither_on & lfsr_q[0]};
        sat_now = sum_v[16] ^ sum_v[15];
        if (sat_now) begin
            vs = sum_v[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            vs = sum_v[15:0];
        end
    end

    // Taps 16,14,13,11 of the polynomial map to bits 0,2,3,5 of a right-shifting register.
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign warm_next = warm_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        lfsr_d      = lfsr_q;
        y_d         = y_q;
        err_d       = err_q;
        sat_d       = sat_q;
        valid_d     = 1'b0;
        sat_count_d = sat_count_q;

        if (en) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            err_d  = {{QBITS{1'b0}}, vs[EBITS-1:0]};
            if (sat_now && (sat_count_q != 8'hFF)) begin
                sat_count_d = sat_count_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    warm_cnt_d = 8'd1;
                    state_d    = (WARM_N <= 8'd1) ? ST_RUN : ST_WARM;
                end
                ST_WARM: begin
                    warm_cnt_d = warm_next;
                    if (warm_next >= WARM_N) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    y_d     = vs[15:EBITS];
                    sat_d   = sat_now;
                    valid_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (clr) begin
            sat_count_d = 8'd0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            warm_cnt_q  <= 8'd0;
            lfsr_q      <= SEED;
            y_q         <= '0;
            err_q       <= 16'd0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            sat_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            lfsr_q      <= lfsr_d;
            y_q         <= y_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            sat_q       <= sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign y         = y_q;
    assign err       = err_q;
    assign valid     = valid_q;
    assign sat       = sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_ds_requantizer.sv
// Self-checking bench for ds_requantizer: directed vector table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_ds_requantizer;

    localparam int QB   = 4;
    localparam int WU   = 2;
    localparam int STEP = 1 << (16 - QB);

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          en_s = 1'b0;
    logic [15:0]   in_s = 16'd0;
    logic [15:0]   fb_s = 16'd0;
    logic          dither_s = 1'b0;
    logic          clr_s = 1'b0;
    logic [QB-1:0] y_o;
    logic [15:0]   err_o;
    logic          valid_o;
    logic          sat_o;
    logic [7:0]    sat_count_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_lfsr;
    int          m_n;
    logic [QB-1:0] m_y;
    logic [15:0] m_err;
    logic        m_sat;
    int          m_cnt;
    logic        m_valid;

    ds_requantizer #(.QBITS(QB), .WARMUP(WU)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .en        (en_s),
        .in        (in_s),
        .fb        (fb_s),
        .dither_on (dither_s),
        .clr       (clr_s),
        .y         (y_o),
        .err       (err_o),
        .valid     (valid_o),
        .sat       (sat_o),
        .sat_count (sat_count_o)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic nb;
        nb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {nb, s[15:1]};
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_n     = 0;
        m_y     = '0;
        m_err   = 16'd0;
        m_sat   = 1'b0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"},         32'(y_o),         32'(m_y));
        check({tag, ".err"},       32'(err_o),       32'(m_err));
        check({tag, ".valid"},     32'(valid_o),     32'(m_valid));
        check({tag, ".sat"},       32'(sat_o),       32'(m_sat));
        check({tag, ".sat_count"}, 32'(sat_count_o), 32'(m_cnt));
    endtask

    // Arithmetic view of one accepted sample: saturate, then floor-divide by the step.
    task automatic model_sample(input logic [15:0] i_v, input logic [15:0] f_v,
                                input logic d_on, input logic c_v);
        int v, vs, q, e, d;
        logic satf;
        d  = (d_on && m_lfsr[0]) ? 1 : 0;
        v  = int'($signed(i_v)) + int'($signed(f_v)) + d;
        satf = 1'b0;
        vs = v;
        if (v > 32767) begin vs = 32767; satf = 1'b1; end
        if (v < -32768) begin vs = -32768; satf = 1'b1; end
        q = vs / STEP;
        if ((vs % STEP != 0) && (vs < 0)) q = q - 1;
        e = vs - q * STEP;
        m_lfsr = lfsr_step(m_lfsr);
        m_n++;
        m_err = 16'(e);
        if (satf && m_cnt < 255) m_cnt++;
        if (c_v) m_cnt = 0;
        m_valid = (m_n > WU);
        if (m_valid) begin
            m_y   = QB'(q);
            m_sat = satf;
        end
    endtask

    task automatic sample(input logic [15:0] i_v, input logic [15:0] f_v,
                          input logic d_on, input logic c_v, input string tag);
        @(negedge CLK);
        in_s = i_v; fb_s = f_v; dither_s = d_on; clr_s = c_v; en_s = 1'b1;
        model_sample(i_v, f_v, d_on, c_v);
        @(posedge CLK);
        #1;
        en_s = 1'b0; clr_s = 1'b0;
        check_all(tag);
    endtask

    task automatic idle_cycle(input logic c_v, input string tag);
        @(negedge CLK);
        en_s = 1'b0; clr_s = c_v;
        in_s = 16'($urandom); fb_s = 16'($urandom);
        if (c_v) m_cnt = 0;
        m_valid = 1'b0;
        @(posedge CLK);
        #1;
        clr_s = 1'b0;
        check_all(tag);
    endtask

    typedef struct {
        logic [15:0]   i;
        logic [15:0]   f;
        logic [QB-1:0] y;
        logic [15:0]   e;
        logic          v;
        logic          s;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'h1234, 16'h0000, 4'h0, 16'h0234, 1'b0, 1'b0};
        tbl[1] = '{16'h1234, 16'h0000, 4'h0, 16'h0234, 1'b0, 1'b0};
        tbl[2] = '{16'h1234, 16'h0000, 4'h1, 16'h0234, 1'b1, 1'b0};
        tbl[3] = '{16'h7000, 16'h2000, 4'h7, 16'h0FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0100, 16'h0000, 4'h0, 16'h0100, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'hF000, 4'h8, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'hFFFF, 16'h0000, 4'hF, 16'h0FFF, 1'b1, 1'b0};
        tbl[7] = '{16'h7FFF, 16'h0000, 4'h7, 16'h0FFF, 1'b1, 1'b0};
        tbl[8] = '{16'h7FFF, 16'h0001, 4'h7, 16'h0FFF, 1'b1, 1'b1};
        tbl[9] = '{16'h8000, 16'h0000, 4'h8, 16'h0000, 1'b1, 1'b0};

        // reset held low while en toggles
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            en_s = ~en_s; in_s = 16'($urandom); fb_s = 16'($urandom);
            @(posedge CLK);
            #1;
            check_all("reset");
        end
        @(negedge CLK);
        en_s = 1'b0;
        reset = 1'b1;

        // warm-up and directed RUN vectors
        for (int k = 0; k < 10; k++) begin
            sample(tbl[k].i, tbl[k].f, 1'b0, 1'b0, $sformatf("vec%0d", k));
            check($sformatf("vec%0d.tbl_y", k),   32'(y_o),     32'(tbl[k].y));
            check($sformatf("vec%0d.tbl_err", k), 32'(err_o),   32'(tbl[k].e));
            check($sformatf("vec%0d.tbl_vld", k), 32'(valid_o), 32'(tbl[k].v));
            check($sformatf("vec%0d.tbl_sat", k), 32'(sat_o),   32'(tbl[k].s));
            if (k == 3) check("sat_cnt_first", 32'(sat_count_o), 32'd1);
        end
        idle_cycle(1'b0, "hold");

        // sat_count saturation then clr with a saturating sample
        for (int k = 0; k < 300; k++) begin
            sample((k % 2 == 0) ? 16'h7FFF : 16'h8000, (k % 2 == 0) ? 16'h7FFF : 16'h8000,
                   1'b0, 1'b0, "satrun");
        end
        check("sat_count_ceiling", 32'(sat_count_o), 32'h0000_00FF);
        sample(16'h8000, 16'hF000, 1'b0, 1'b1, "clr_sat");
        check("sat_count_clr", 32'(sat_count_o), 32'd0);

        // dither after a fresh reset and a dither-free warm-up
        @(negedge CLK);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset2");
        @(negedge CLK);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) sample(16'h0000, 16'h0000, 1'b0, 1'b0, "warm2");
        sample(16'h0000, 16'h0000, 1'b1, 1'b0, "dither");
        check("dither_err", 32'(err_o), 32'(lfsr_step(lfsr_step(lfsr_step(16'hACE1))) & 16'h1));
        check("dither_y", 32'(y_o), 32'd0);

        // randomized traffic with gaps, dither and occasional clr
        for (int k = 0; k < 500; k++) begin
            logic [15:0] ri, rf;
            ri = 16'($urandom);
            rf = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 511))) - 16'sd256);
            if ($urandom_range(0, 4) == 0) idle_cycle(($urandom_range(0, 15) == 0), "rnd_idle");
            else sample(ri, rf, 1'($urandom), ($urandom_range(0, 31) == 0), "rnd");
        end

        // asynchronous reset mid-RUN
        @(negedge CLK);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        @(negedge CLK);
        reset = 1'b1;
        sample(16'h0000, 16'h0000, 1'b1, 1'b0, "post1");
        check("post1_seed_dither", 32'(err_o), 32'h0000_0001);
        sample(16'h2345, 16'h0010, 1'b0, 1'b0, "post2");
        check("post2_no_valid", 32'(valid_o), 32'd0);
        sample(16'h2345, 16'h0010, 1'b0, 1'b0, "post3");
        check("post3_valid", 32'(valid_o), 32'd1);
        idle_cycle(1'b0, "post_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
